// File: rtl/dmem_arb_pkg.sv
// Shared types and constants for the data-memory arbiter.
package dmem_arb_pkg;

    typedef enum logic [1:0] {
        NONE = 2'd0,
        CORE = 2'd1,
        DBG  = 2'd2
    } owner_e;

    localparam int unsigned HOLD_W   = 4;
    localparam int unsigned NUM_REQ  = 2;
    localparam int unsigned REQ_CORE = 0;
    localparam int unsigned REQ_DBG  = 1;

    // Requester index (0 = core, 1 = debug) to owner encoding.
    function automatic owner_e idx_to_owner(input logic idx);
        return idx ? DBG : CORE;
    endfunction

endpackage

// File: rtl/arb_grant_fsm.sv
// Round-robin grant logic with bounded hold: tracks owner, tie-break priority
// and the count of consecutive grants to the current owner.
module arb_grant_fsm
    import dmem_arb_pkg::*;
#(
    parameter int unsigned MAX_HOLD = 4
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [NUM_REQ-1:0] req_i,
    output logic [NUM_REQ-1:0] gnt_c
);

    localparam logic [HOLD_W-1:0] HOLD_MAX = HOLD_W'(MAX_HOLD);

    owner_e            owner_q, owner_d;
    logic              prio_q,  prio_d;
    logic [HOLD_W-1:0] hold_q,  hold_d;

    logic owner_idx;
    logic holding;
    logic win_idx;

    always_ff @(posedge clk) begin
        if (reset) begin
            owner_q <= NONE;
            prio_q  <= 1'(REQ_CORE);
            hold_q  <= '0;
        end else begin
            owner_q <= owner_d;
            prio_q  <= prio_d;
            hold_q  <= hold_d;
        end
    end

    always_comb begin
        gnt_c     = '0;
        owner_d   = owner_q;
        prio_d    = prio_q;
        hold_d    = hold_q;
        owner_idx = (owner_q == DBG);
        holding   = (owner_q != NONE) && req_i[owner_idx] && (hold_q < HOLD_MAX);
        win_idx   = 1'b0;

        if (!reset) begin
            unique case (req_i)
                2'b01:   gnt_c[REQ_CORE] = 1'b1;
                2'b10:   gnt_c[REQ_DBG]  = 1'b1;
                2'b11: begin
                    if (holding) gnt_c[owner_idx] = 1'b1;
                    else         gnt_c[prio_q]    = 1'b1;
                end
                default: gnt_c = '0;
            endcase
        end

        win_idx = gnt_c[REQ_DBG];

        // A new owner restarts its run and hands the next tie to the other side.
        if (gnt_c == '0) begin
            owner_d = NONE;
            hold_d  = '0;
        end else if (idx_to_owner(win_idx) == owner_q) begin
            hold_d = (hold_q < HOLD_MAX) ? hold_q + HOLD_W'(1) : hold_q;
        end else begin
            owner_d = idx_to_owner(win_idx);
            hold_d  = HOLD_W'(1);
            prio_d  = ~win_idx;
        end
    end

endmodule

// File: rtl/dmem_arbiter.sv
// Shares one data-memory port between the core datapath and the debug/loader
// port; owns the address/data mux and the 1-cycle read-return register.
module dmem_arbiter
    import dmem_arb_pkg::*;
#(
    parameter int unsigned ADDR_W   = 16,
    parameter int unsigned DATA_W   = 16,
    parameter int unsigned MAX_HOLD = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              core_req,
    input  logic              core_we,
    input  logic [ADDR_W-1:0] core_addr,
    input  logic [DATA_W-1:0] core_wdata,
    output logic              core_gnt,
    output logic              core_stall,
    output logic              core_rvalid,
    input  logic              dbg_req,
    input  logic              dbg_we,
    input  logic [ADDR_W-1:0] dbg_addr,
    input  logic [DATA_W-1:0] dbg_wdata,
    output logic              dbg_gnt,
    output logic              dbg_rvalid,
    output logic [DATA_W-1:0] rdata,
    output logic [ADDR_W-1:0] mem_access_addr,
    output logic [DATA_W-1:0] mem_write_data,
    output logic              mem_write_en,
    output logic              mem_read,
    input  logic [DATA_W-1:0] mem_read_data
);

    logic [NUM_REQ-1:0] req;
    logic [NUM_REQ-1:0] gnt;
    logic               sel_we;

    logic              core_rvalid_q;
    logic              dbg_rvalid_q;
    logic [DATA_W-1:0] rdata_q;

    assign req[REQ_CORE] = core_req;
    assign req[REQ_DBG]  = dbg_req;

    arb_grant_fsm #(
        .MAX_HOLD (MAX_HOLD)
    ) u_grant (
        .clk   (clk),
        .reset (reset),
        .req_i (req),
        .gnt_c (gnt)
    );

    assign core_gnt   = gnt[REQ_CORE];
    assign dbg_gnt    = gnt[REQ_DBG];
    assign core_stall = core_req & ~core_gnt;

    // Memory-side mux; idle cycles drive zeros with enables low.
    always_comb begin
        mem_access_addr = '0;
        mem_write_data  = '0;
        sel_we          = 1'b0;
        if (gnt[REQ_CORE]) begin
            mem_access_addr = core_addr;
            mem_write_data  = core_wdata;
            sel_we          = core_we;
        end else if (gnt[REQ_DBG]) begin
            mem_access_addr = dbg_addr;
            mem_write_data  = dbg_wdata;
            sel_we          = dbg_we;
        end
        mem_write_en = (|gnt) & sel_we;
        mem_read     = (|gnt) & ~sel_we;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            core_rvalid_q <= 1'b0;
            dbg_rvalid_q  <= 1'b0;
            rdata_q       <= '0;
        end else begin
            core_rvalid_q <= gnt[REQ_CORE] & ~core_we;
            dbg_rvalid_q  <= gnt[REQ_DBG]  & ~dbg_we;
            if (mem_read) begin
                rdata_q <= mem_read_data;
            end
        end
    end

    // An in-flight return is dropped in the very cycle reset is raised.
    assign core_rvalid = core_rvalid_q & ~reset;
    assign dbg_rvalid  = dbg_rvalid_q  & ~reset;
    assign rdata       = reset ? '0 : rdata_q;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Bench for dmem_arbiter: directed vector table plus randomized traffic
// checked against a behavioural arbitration model.
module tb_dmem_arbiter;

    localparam int unsigned AW = 16;
    localparam int unsigned DW = 16;
    localparam int MH = 4;
    localparam int NV = 27;
    localparam int NRAND = 400;

    localparam logic [15:0] CA = 16'h0010;
    localparam logic [15:0] DA = 16'h0020;
    localparam logic [15:0] CW = 16'h1111;
    localparam logic [15:0] DWD = 16'h2222;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          reset;
    logic          core_req, core_we, core_gnt, core_stall, core_rvalid;
    logic [AW-1:0] core_addr;
    logic [DW-1:0] core_wdata;
    logic          dbg_req, dbg_we, dbg_gnt, dbg_rvalid;
    logic [AW-1:0] dbg_addr;
    logic [DW-1:0] dbg_wdata;
    logic [DW-1:0] rdata;
    logic [AW-1:0] mem_access_addr;
    logic [DW-1:0] mem_write_data;
    logic          mem_write_en, mem_read;
    logic [DW-1:0] mem_read_data;

    logic [15:0] tb_mem [0:255];

    assign mem_read_data = tb_mem[mem_access_addr[7:0]];

    dmem_arbiter dut (
        .clk             (clk),
        .reset           (reset),
        .core_req        (core_req),
        .core_we         (core_we),
        .core_addr       (core_addr),
        .core_wdata      (core_wdata),
        .core_gnt        (core_gnt),
        .core_stall      (core_stall),
        .core_rvalid     (core_rvalid),
        .dbg_req         (dbg_req),
        .dbg_we          (dbg_we),
        .dbg_addr        (dbg_addr),
        .dbg_wdata       (dbg_wdata),
        .dbg_gnt         (dbg_gnt),
        .dbg_rvalid      (dbg_rvalid),
        .rdata           (rdata),
        .mem_access_addr (mem_access_addr),
        .mem_write_data  (mem_write_data),
        .mem_write_en    (mem_write_en),
        .mem_read        (mem_read),
        .mem_read_data   (mem_read_data)
    );

    typedef struct {
        logic        rst, creq, cwe;
        logic [15:0] caddr, cwd;
        logic        dreq, dwe;
        logic [15:0] daddr, dwd;
        logic        cg, dg, rd, wr;
        logic [15:0] maddr, mwd;
        logic        crv, drv;
        logic [15:0] rdat;
    } vec_t;

    vec_t vecs [NV];
    int   n_chk  = 0;
    int   n_pass = 0;

    function automatic vec_t mk(
        input logic rst, input logic creq, input logic cwe,
        input logic [15:0] caddr, input logic [15:0] cwd,
        input logic dreq, input logic dwe,
        input logic [15:0] daddr, input logic [15:0] dwd,
        input logic cg, input logic dg, input logic rd, input logic wr,
        input logic [15:0] maddr, input logic [15:0] mwd,
        input logic crv, input logic drv, input logic [15:0] rdat);
        vec_t v;
        v.rst = rst;  v.creq = creq; v.cwe = cwe; v.caddr = caddr; v.cwd = cwd;
        v.dreq = dreq; v.dwe = dwe; v.daddr = daddr; v.dwd = dwd;
        v.cg = cg; v.dg = dg; v.rd = rd; v.wr = wr; v.maddr = maddr; v.mwd = mwd;
        v.crv = crv; v.drv = drv; v.rdat = rdat;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) $display("FAIL %s: got %0h, want %0h", name, act, exp);
        else             n_pass++;
    endtask

    task automatic drive(input logic rst, input logic creq, input logic cwe,
                         input logic [15:0] caddr, input logic [15:0] cwd,
                         input logic dreq, input logic dwe,
                         input logic [15:0] daddr, input logic [15:0] dwd);
        reset = rst; core_req = creq; core_we = cwe; core_addr = caddr; core_wdata = cwd;
        dbg_req = dreq; dbg_we = dwe; dbg_addr = daddr; dbg_wdata = dwd;
    endtask

    // Advance one clock; the bench plays the memory and commits any write at the edge.
    task automatic step();
        logic        we;
        logic [7:0]  a;
        logic [15:0] d;
        we = mem_write_en;
        a  = mem_access_addr[7:0];
        d  = mem_write_data;
        @(posedge clk);
        if (we === 1'b1) tb_mem[a] = d;
        #1;
    endtask

    task automatic chk_outputs(input string tag, input logic cg, input logic dg,
                               input logic stall, input logic rd, input logic wr,
                               input logic [15:0] maddr, input logic [15:0] mwd,
                               input logic crv, input logic drv, input logic [15:0] rdat);
        chk({tag, "_core_gnt"},   32'(core_gnt),        32'(cg));
        chk({tag, "_dbg_gnt"},    32'(dbg_gnt),         32'(dg));
        chk({tag, "_stall"},      32'(core_stall),      32'(stall));
        chk({tag, "_mem_read"},   32'(mem_read),        32'(rd));
        chk({tag, "_mem_we"},     32'(mem_write_en),    32'(wr));
        chk({tag, "_mem_addr"},   32'(mem_access_addr), 32'(maddr));
        chk({tag, "_mem_wdata"},  32'(mem_write_data),  32'(mwd));
        chk({tag, "_core_rv"},    32'(core_rvalid),     32'(crv));
        chk({tag, "_dbg_rv"},     32'(dbg_rvalid),      32'(drv));
        chk({tag, "_rdata"},      32'(rdata),           32'(rdat));
    endtask

    initial begin
        int          m_own, m_tie, m_streak, p_who, w, nxt_who;
        logic [15:0] m_rdata, nxt_data, e_addr, e_wd;
        logic        e_we, r_rst, r_cq, r_cw, r_dq, r_dw;
        logic [15:0] r_ca, r_cd, r_da, r_dd;

        for (int i = 0; i < 256; i++) tb_mem[i] = 16'(i * 257) ^ 16'h3C00;
        tb_mem[8'h10] = 16'hBEEF;
        tb_mem[8'h20] = 16'h5A5A;

        // Reset, single read, debug write, contention with hold, early release, reset mid-read.
        vecs[0]  = mk(1, 1,0,CA,CW, 1,0,DA,DWD, 0,0,0,0,16'h0,16'h0, 0,0,16'h0000);
        vecs[1]  = mk(1, 1,0,CA,CW, 1,0,DA,DWD, 0,0,0,0,16'h0,16'h0, 0,0,16'h0000);
        vecs[2]  = mk(0, 1,0,CA,CW, 0,0,DA,DWD, 1,0,1,0,CA,CW,       0,0,16'h0000);
        vecs[3]  = mk(0, 0,0,CA,CW, 0,0,DA,DWD, 0,0,0,0,16'h0,16'h0, 1,0,16'hBEEF);
        vecs[4]  = mk(0, 0,0,CA,CW, 1,1,16'h0040,16'h1234, 0,1,0,1,16'h0040,16'h1234, 0,0,16'hBEEF);
        vecs[5]  = mk(0, 0,0,CA,CW, 0,0,DA,DWD, 0,0,0,0,16'h0,16'h0, 0,0,16'hBEEF);
        vecs[6]  = mk(0, 1,0,CA,CW, 1,0,DA,DWD, 1,0,1,0,CA,CW,       0,0,16'hBEEF);
        for (int i = 7; i <= 9; i++)
            vecs[i] = mk(0, 1,0,CA,CW, 1,0,DA,DWD, 1,0,1,0,CA,CW,    1,0,16'hBEEF);
        vecs[10] = mk(0, 1,0,CA,CW, 1,0,DA,DWD, 0,1,1,0,DA,DWD,      1,0,16'hBEEF);
        for (int i = 11; i <= 13; i++)
            vecs[i] = mk(0, 1,0,CA,CW, 1,0,DA,DWD, 0,1,1,0,DA,DWD,   0,1,16'h5A5A);
        vecs[14] = mk(0, 1,0,CA,CW, 1,0,DA,DWD, 1,0,1,0,CA,CW,       0,1,16'h5A5A);
        vecs[15] = mk(0, 1,0,CA,CW, 1,0,DA,DWD, 1,0,1,0,CA,CW,       1,0,16'hBEEF);
        vecs[16] = mk(0, 0,0,CA,CW, 1,0,DA,DWD, 0,1,1,0,DA,DWD,      1,0,16'hBEEF);
        for (int i = 17; i <= 19; i++)
            vecs[i] = mk(0, 1,0,CA,CW, 1,0,DA,DWD, 0,1,1,0,DA,DWD,   0,1,16'h5A5A);
        vecs[20] = mk(0, 1,0,CA,CW, 1,0,DA,DWD, 1,0,1,0,CA,CW,       0,1,16'h5A5A);
        vecs[21] = mk(0, 1,0,CA,CW, 0,0,DA,DWD, 1,0,1,0,CA,CW,       1,0,16'hBEEF);
        vecs[22] = mk(1, 1,0,CA,CW, 1,0,DA,DWD, 0,0,0,0,16'h0,16'h0, 0,0,16'h0000);
        vecs[23] = mk(0, 1,0,CA,CW, 1,0,DA,DWD, 1,0,1,0,CA,CW,       0,0,16'h0000);
        vecs[24] = mk(0, 1,0,CA,CW, 1,0,DA,DWD, 1,0,1,0,CA,CW,       1,0,16'hBEEF);
        vecs[25] = mk(0, 0,0,CA,CW, 0,0,DA,DWD, 0,0,0,0,16'h0,16'h0, 1,0,16'hBEEF);
        vecs[26] = mk(0, 0,0,CA,CW, 0,0,DA,DWD, 0,0,0,0,16'h0,16'h0, 0,0,16'hBEEF);

        for (int i = 0; i < NV; i++) begin
            vec_t v;
            v = vecs[i];
            drive(v.rst, v.creq, v.cwe, v.caddr, v.cwd, v.dreq, v.dwe, v.daddr, v.dwd);
            #2;
            chk_outputs($sformatf("v%0d", i), v.cg, v.dg, v.creq & ~v.cg, v.rd, v.wr,
                        v.maddr, v.mwd, v.crv, v.drv, v.rdat);
            step();
        end

        // Randomized traffic against the arbitration rules, tracked with plain integers.
        m_own = 0; m_tie = 1; m_streak = 0; p_who = 0; m_rdata = 16'h0;
        for (int k = 0; k < NRAND; k++) begin
            r_rst = (k < 2) || ($urandom_range(0, 63) == 0);
            r_cq  = ($urandom_range(0, 3) != 0);
            r_dq  = ($urandom_range(0, 3) != 0);
            r_cw  = ($urandom_range(0, 2) == 0);
            r_dw  = ($urandom_range(0, 2) == 0);
            r_ca  = 16'($urandom_range(0, 255));
            r_da  = 16'($urandom_range(0, 255));
            r_cd  = 16'($urandom);
            r_dd  = 16'($urandom);
            drive(r_rst, r_cq, r_cw, r_ca, r_cd, r_dq, r_dw, r_da, r_dd);
            #2;

            if (r_rst)              w = 0;
            else if (r_cq && !r_dq) w = 1;
            else if (r_dq && !r_cq) w = 2;
            else if (r_cq && r_dq)  w = (m_own != 0 && m_streak < MH) ? m_own : m_tie;
            else                    w = 0;

            e_addr = (w == 1) ? r_ca : (w == 2) ? r_da : 16'h0;
            e_wd   = (w == 1) ? r_cd : (w == 2) ? r_dd : 16'h0;
            e_we   = (w == 1) ? r_cw : (w == 2) ? r_dw : 1'b0;

            chk_outputs($sformatf("r%0d", k), w == 1, w == 2, r_cq && w != 1,
                        w != 0 && !e_we, w != 0 && e_we, e_addr, e_wd,
                        p_who == 1 && !r_rst, p_who == 2 && !r_rst,
                        r_rst ? 16'h0 : m_rdata);

            nxt_who  = (w != 0 && !e_we) ? w : 0;
            nxt_data = tb_mem[e_addr[7:0]];
            step();

            if (r_rst) begin
                m_own = 0; m_tie = 1; m_streak = 0; p_who = 0; m_rdata = 16'h0;
            end else begin
                if (w == 0) begin
                    m_own = 0; m_streak = 0;
                end else if (w == m_own) begin
                    if (m_streak < MH) m_streak++;
                end else begin
                    m_own = w; m_streak = 1; m_tie = 3 - w;
                end
                p_who = nxt_who;
                if (nxt_who != 0) m_rdata = nxt_data;
            end
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/dmem_arbiter.md
Name: dmem_arbiter

Overview:
- Shares the single data-memory port between two requesters: the core datapath (load/store path, requester 0) and a debug/loader port (requester 1).
- Sits between the datapath's memory-access signals and the Data_Memory instance.
- Round-robin arbitration with bounded grant hold.
- Returns read data with a fixed 1-cycle latency and a per-requester valid.
- Provides a stall output so the datapath can freeze the PC while the core is denied.

Parameters:
- ADDR_W, 16, address width.
- DATA_W, 16, data width.
- MAX_HOLD, 4, maximum consecutive grants to one owner while the other requester waits (legal range 1..15).

Ports:
- clk  in  1  clock.
- reset  in  1  synchronous, active-high reset.
- core_req  in  1  core requests a memory access this cycle.
- core_we  in  1  1 = write, 0 = read.
- core_addr  in  ADDR_W  core address.
- core_wdata  in  DATA_W  core write data.
- core_gnt  out  1  core access is issued this cycle.
- core_stall  out  1  core_req & ~core_gnt.
- core_rvalid  out  1  read data for the core is on rdata this cycle.
- dbg_req  in  1  debug request.
- dbg_we  in  1  debug write enable.
- dbg_addr  in  ADDR_W  debug address.
- dbg_wdata  in  DATA_W  debug write data.
- dbg_gnt  out  1  debug access is issued this cycle.
- dbg_rvalid  out  1  read data for debug is on rdata.
- rdata  out  DATA_W  registered read data, shared by both requesters.
- mem_access_addr  out  ADDR_W  to the data memory.
- mem_write_data  out  DATA_W  to the data memory.
- mem_write_en  out  1  to the data memory.
- mem_read  out  1  to the data memory.
- mem_read_data  in  DATA_W  from the data memory, combinational read.

Behaviour:
- Reset (synchronous; clears regardless of in-flight activity):
  - State: owner=NONE, prio=CORE, hold_cnt=0.
  - Outputs: core_rvalid, dbg_rvalid = 0; rdata = 0.
  - While reset is high: gnts = 0 and mem_write_en/mem_read = 0.
- Grant is combinational from req inputs and registered state; at most one gnt is high per cycle.
- Grant rules, evaluated in order:
  - No req: no grant.
  - Exactly one req: grant it.
  - Both req, owner holding:
    - Condition: owner != NONE, owner's req is still high, and hold_cnt < MAX_HOLD.
    - Result: grant owner.
  - Both req, otherwise: grant the requester indicated by prio.
- State update each cycle:
  - On grant to X == owner: hold_cnt <= hold_cnt+1, saturating at MAX_HOLD.
  - On grant to X != owner: owner <= X, hold_cnt <= 1, prio <= other(X).
  - No grant: owner <= NONE, hold_cnt <= 0.
- Memory mux:
  - Granted requester's addr/wdata are driven onto mem_access_addr/mem_write_data.
  - mem_write_en = gnt & we; mem_read = gnt & ~we.
  - No grant: addr/data driven 0, enables 0.
- Read return:
  - A granted read in cycle t registers mem_read_data into rdata at the end of t.
  - The owner's rvalid is 1 in t+1.
  - Writes never assert rvalid.
  - rdata holds its last value when no read returns.
- Back-to-back reads by either requester are allowed every cycle; throughput is 1 access/cycle.
- core_stall is combinational and may be used directly as the PC-hold enable.
- A requester may change addr/we/wdata freely while not granted. Values are sampled only in the granted cycle.
- hold_cnt width is 4 bits. MAX_HOLD=1 degenerates to strict alternation under contention.

Decomposition:
- Package dmem_arb_pkg holds:
  - owner_e enum {NONE, CORE, DBG};
  - HOLD_W = 4 localparam;
  - requester index constants REQ_CORE=0, REQ_DBG=1.
- One natural sub-module, arb_grant_fsm: owner/prio/hold_cnt registers and grant logic, taking req[1:0] and producing gnt[1:0].
- Top level keeps the address/data mux and the read-return register.

Test Plan:
- Reset: assert reset 2 cycles with both reqs high -> gnts 0, mem_read/mem_write_en 0, rvalids 0, rdata 0x0000.
- Core single read: core_req=1, we=0, addr 0x0010, memory returns 0xBEEF -> expected:
  - same cycle: core_gnt=1, mem_read=1, mem_access_addr=0x0010;
  - next cycle: core_rvalid=1, rdata=0xBEEF, dbg_rvalid=0.
- Contention with hold: both req continuously from the first cycle after reset, MAX_HOLD=4 -> core_gnt cycles 1-4, dbg_gnt cycles 5-8, core_gnt cycle 9; dbg core_stall=1 pattern matches ~core_gnt.
- Early release: both req; core drops req after 2 grants -> dbg_gnt the next cycle, hold_cnt=1, dbg keeps grant up to 4 cycles if core re-requests.
- Debug write: dbg_req=1, we=1, addr 0x0040, wdata 0x1234, core idle -> dbg_gnt=1, mem_write_en=1, mem_read=0, mem_write_data=0x1234; no rvalid next cycle.
- Reset mid-read: core read granted in cycle t, reset high in t+1 -> core_rvalid=0 in t+1 and t+2, rdata=0x0000, owner=NONE, and the first tie after reset goes to core.
